// File: rtl/mem_phase_ctrl.sv
`timescale 1ns/1ps
// mem_phase_ctrl: LOAD/RUN/SHOW sequencer and data-memory port arbiter for the sorting CPU.
// Optional RUN watchdog enabled by defining MEM_PHASE_CTRL_WATCHDOG_EN.
module mem_phase_ctrl #(
  parameter int DEPTH = 10,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int SHOW_HOLD = 50_000_000,
  parameter int WDOG_LIMIT = 1_000_000
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              btn_pulse,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              cpu_halt,
  input  logic              cpu_mem_we,
  input  logic [ADDR_W-1:0] cpu_mem_waddr,
  input  logic [DATA_W-1:0] cpu_mem_wdata,
  input  logic [ADDR_W-1:0] cpu_mem_raddr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              cpu_run,
  output logic              over,
  output logic              sortover,
  output logic [DEPTH-1:0]  led,
  output logic              timeout
);
  typedef enum logic [1:0] {LOAD, RUN, SHOW} phase_t;
  localparam int HW = SHOW_HOLD > 1 ? $clog2(SHOW_HOLD) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  phase_t state, state_n;
  logic [ADDR_W-1:0] load_cnt, show_idx, ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [HW-1:0] hold_cnt;
  logic ld_we, accept, hold_done, wdog_fire;
  assign accept = state == LOAD && btn_pulse;
  assign hold_done = hold_cnt == HW'(SHOW_HOLD - 1);
  always_comb begin
    state_n = (accept && load_cnt == LAST) ? RUN :
              (state == RUN && (cpu_halt || wdog_fire)) ? SHOW : state;
  end
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state <= LOAD;
      load_cnt <= '0;
      show_idx <= '0;
      hold_cnt <= '0;
      ld_we <= 1'b0;
      ld_addr <= '0;
      ld_data <= '0;
    end else begin
      state <= state_n;
      ld_we <= accept;
      if (accept) begin
        ld_addr <= load_cnt;
        ld_data <= sw_data;
        if (load_cnt != LAST) load_cnt <= load_cnt + 1'b1;
      end
      if (state == SHOW) begin
        hold_cnt <= hold_done ? '0 : hold_cnt + 1'b1;
        if (hold_done) show_idx <= show_idx == LAST ? '0 : show_idx + 1'b1;
      end
    end
  end
  // The final load write lands in the first RUN cycle; the pipeline cannot reach MEM that early.
  always_comb begin
    mem_we = ld_we ? 1'b1 : (state == RUN && cpu_mem_we);
    mem_waddr = ld_we ? ld_addr : state == RUN ? cpu_mem_waddr : '0;
    mem_wdata = ld_we ? ld_data : state == RUN ? cpu_mem_wdata : '0;
    mem_raddr = state == RUN ? cpu_mem_raddr : state == SHOW ? show_idx : '0;
    cpu_run = state == RUN;
    over = state != LOAD;
    sortover = state == SHOW;
    led = state == LOAD ? DEPTH'(1) << (LAST - load_cnt) :
          state == SHOW ? DEPTH'(1) << (LAST - show_idx) : '0;
  end
`ifdef MEM_PHASE_CTRL_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  logic [WW-1:0] wdog_cnt;
  logic timeout_q;
  assign wdog_fire = state == RUN && wdog_cnt == WW'(WDOG_LIMIT - 1);
  always_ff @(posedge Clk) begin
    if (Clr) begin
      wdog_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_cnt <= state == RUN ? wdog_cnt + 1'b1 : '0;
      if (wdog_fire && !cpu_halt) timeout_q <= 1'b1;
    end
  end
  assign timeout = timeout_q;
`else
  assign wdog_fire = 1'b0;
  assign timeout = WDOG_LIMIT < 0;
`endif
endmodule

// File: tb/tb_mem_phase_ctrl.sv
`timescale 1ns/1ps
// tb_mem_phase_ctrl: directed-random bench for mem_phase_ctrl with arithmetic expectations.
module tb_mem_phase_ctrl;
  localparam int HOLD = 4;
  logic clk = 1'b0, Clr = 1'b1, btn_pulse = 1'b0, cpu_halt = 1'b0, cpu_mem_we = 1'b0;
  logic [15:0] sw_data = '0, cpu_mem_wdata = '0, mem_wdata;
  logic [3:0] cpu_mem_waddr = '0, cpu_mem_raddr = '0, mem_waddr, mem_raddr;
  logic mem_we, cpu_run, over, sortover, timeout;
  logic [9:0] led;
  int errors = 0, checks = 0;
  mem_phase_ctrl #(.DEPTH(10), .DATA_W(16), .ADDR_W(4), .SHOW_HOLD(HOLD), .WDOG_LIMIT(20)) dut (
    .Clk(clk), .Clr(Clr), .btn_pulse(btn_pulse), .sw_data(sw_data), .cpu_halt(cpu_halt),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_waddr(cpu_mem_waddr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_raddr(cpu_mem_raddr), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .cpu_run(cpu_run), .over(over), .sortover(sortover), .led(led),
    .timeout(timeout));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic rand_cpu();
    cpu_mem_we = 1'($urandom);
    cpu_mem_waddr = 4'($urandom);
    cpu_mem_wdata = 16'($urandom);
    cpu_mem_raddr = 4'($urandom);
  endtask
  function automatic logic [31:0] onehot(input int idx);
    return 32'(10'(1) << (9 - idx));
  endfunction
  task automatic check_reset(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_waddr"}, 32'(mem_waddr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_raddr"}, 32'(mem_raddr), 0);
    chk({tag, "_run"}, 32'(cpu_run), 0);
    chk({tag, "_over"}, 32'(over), 0);
    chk({tag, "_sortover"}, 32'(sortover), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_led"}, 32'(led), 32'h200);
  endtask
  task automatic load_word(input int i, input logic [15:0] d, input int gap);
    repeat (gap) begin
      tick();
      rand_cpu();
      #1;
      chk("load_idle_we", 32'(mem_we), 0);
      chk("load_idle_over", 32'(over), 0);
      chk("load_idle_led", 32'(led), onehot(i));
    end
    btn_pulse = 1'b1;
    sw_data = d;
    tick();
    btn_pulse = 1'b0;
    sw_data = 16'($urandom);
    rand_cpu();
    #1;
    chk("load_we", 32'(mem_we), 1);
    chk("load_waddr", 32'(mem_waddr), 32'(i));
    chk("load_wdata", 32'(mem_wdata), 32'(d));
    chk("load_run", 32'(cpu_run), 32'(i == 9));
    chk("load_over", 32'(over), 32'(i == 9));
    chk("load_led", 32'(led), i == 9 ? 0 : onehot(i + 1));
    chk("load_sortover", 32'(sortover), 0);
  endtask
  initial begin
    repeat (3) tick();
    check_reset("in_clr");
    Clr = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      rand_cpu();
      #1;
      check_reset("reset_hold");
    end
    for (int i = 0; i < 10; i++) load_word(i, 16'(9 - i), $urandom_range(0, 2));
    for (int c = 0; c < 8; c++) begin
      tick();
      rand_cpu();
      btn_pulse = 1'($urandom);
      #1;
      chk("run_we", 32'(mem_we), 32'(cpu_mem_we));
      chk("run_waddr", 32'(mem_waddr), 32'(cpu_mem_waddr));
      chk("run_wdata", 32'(mem_wdata), 32'(cpu_mem_wdata));
      chk("run_raddr", 32'(mem_raddr), 32'(cpu_mem_raddr));
      chk("run_flags", {29'd0, cpu_run, over, sortover}, 32'b110);
      chk("run_led", 32'(led), 0);
    end
    btn_pulse = 1'b0;
    tick();
    cpu_halt = 1'b1;
    cpu_mem_we = 1'b1;
    cpu_mem_waddr = 4'd3;
    cpu_mem_wdata = 16'h00AA;
    #1;
    chk("halt_we", 32'(mem_we), 1);
    chk("halt_waddr", 32'(mem_waddr), 3);
    chk("halt_wdata", 32'(mem_wdata), 32'h00AA);
    chk("halt_run", 32'(cpu_run), 1);
    tick();
    cpu_halt = 1'b0;
    for (int k = 0; k < HOLD * 11; k++) begin
      if (k > 0) tick();
      rand_cpu();
      btn_pulse = 1'($urandom);
      #1;
      chk("show_raddr", 32'(mem_raddr), 32'((k / HOLD) % 10));
      chk("show_led", 32'(led), onehot((k / HOLD) % 10));
      chk("show_we", 32'(mem_we), 0);
      chk("show_flags", {29'd0, cpu_run, over, sortover}, 32'b011);
    end
    btn_pulse = 1'b0;
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    #1;
    check_reset("clr_show");
    for (int i = 0; i < 5; i++) load_word(i, 16'($urandom), $urandom_range(0, 1));
    Clr = 1'b1;
    btn_pulse = 1'b1;
    tick();
    Clr = 1'b0;
    btn_pulse = 1'b0;
    #1;
    check_reset("clr_load");
    tick();
    chk("clr_load_after_we", 32'(mem_we), 0);
    for (int i = 0; i < 10; i++) load_word(i, 16'($urandom), $urandom_range(0, 2));
`ifdef MEM_PHASE_CTRL_WATCHDOG_EN
    for (int k = 1; k < 20; k++) begin
      tick();
      chk("wdog_run", 32'(cpu_run), 1);
      chk("wdog_timeout_early", 32'(timeout), 0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wdog_fired", {29'd0, cpu_run, sortover, timeout}, 32'b011);
    end
`else
    for (int k = 1; k <= 1000; k++) begin
      tick();
      chk("nowdog_run", {29'd0, cpu_run, sortover, timeout}, 32'b100);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
